// File: rtl/recon_slot_manager.sv
// Recon slot manager: decodes a recon header in beat 0 of each frame, stores bitstreams via a
// DMA write descriptor plus realigned payload, and loads them via DMA read from a slot table.
module recon_slot_manager #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 34,
  parameter int unsigned LEN_WIDTH  = 20,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned HDR_OFFSET = 46,
  parameter int unsigned NUM_SLOTS  = 8,
  localparam int unsigned DATA_BYTES = DATA_WIDTH / 8,
  localparam int unsigned KEEP_WIDTH = DATA_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ADDR_WIDTH-1:0] m_axis_write_desc_addr,
  output logic [LEN_WIDTH-1:0]  m_axis_write_desc_len,
  output logic [TAG_WIDTH-1:0]  m_axis_write_desc_tag,
  output logic                  m_axis_write_desc_valid,
  input  logic                  m_axis_write_desc_ready,
  output logic [ADDR_WIDTH-1:0] m_axis_read_desc_addr,
  output logic [LEN_WIDTH-1:0]  m_axis_read_desc_len,
  output logic [TAG_WIDTH-1:0]  m_axis_read_desc_tag,
  output logic                  m_axis_read_desc_valid,
  input  logic                  m_axis_read_desc_ready,
  input  logic [TAG_WIDTH-1:0]  s_axis_read_desc_status_tag,
  input  logic                  s_axis_read_desc_status_valid,
  output logic [NUM_SLOTS-1:0]  stat_slot_valid,
  output logic                  stat_err,
  output logic                  busy
);

  localparam int unsigned SHIFT  = HDR_OFFSET + 10;
  localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned HB     = HDR_OFFSET * 8;

  typedef enum logic [2:0] {
    StIdle, StWrDesc, StStream, StFlush, StRdDesc, StRdWait, StDrop
  } state_e;

  state_e state_q, state_d;

  logic [1:0]        hdr_func;
  logic              hdr_size_valid;
  logic [33:0]       hdr_addr;
  logic [7:0]        hdr_id;
  logic [31:0]       hdr_size;
  logic [SLOT_W-1:0] hdr_slot;
  logic              id_ok, size_ok;

  assign hdr_func       = s_axis_tdata[HB +: 2];
  assign hdr_size_valid = s_axis_tdata[HB + 2];
  assign hdr_addr       = s_axis_tdata[HB + 3 +: 34];
  assign hdr_id         = s_axis_tdata[HB + 37 +: 8];
  assign hdr_size       = s_axis_tdata[HB + 45 +: 32];
  assign hdr_slot       = hdr_id[SLOT_W-1:0];
  assign id_ok          = 32'(hdr_id) < NUM_SLOTS;
  assign size_ok        = (hdr_size != 32'd0) && ((hdr_size >> LEN_WIDTH) == 32'd0);

  logic [NUM_SLOTS-1:0]  tbl_valid_q, tbl_valid_d;
  logic [ADDR_WIDTH-1:0] tbl_addr_q [NUM_SLOTS];
  logic [LEN_WIDTH-1:0]  tbl_size_q [NUM_SLOTS];
  logic                  tbl_we;

  logic [ADDR_WIDTH-1:0] wd_addr_q, wd_addr_d, rd_addr_q, rd_addr_d;
  logic [LEN_WIDTH-1:0]  wd_len_q, wd_len_d, rd_len_q, rd_len_d;
  logic [TAG_WIDTH-1:0]  wd_tag_q, wd_tag_d, rd_tag_q, rd_tag_d;
  logic                  wd_valid_q, wd_valid_d, rd_valid_q, rd_valid_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic                  hdr_last_q, hdr_last_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [KEEP_WIDTH-1:0] res_keep_q, res_keep_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d, out_data;
  logic [KEEP_WIDTH-1:0] mkeep_q, mkeep_d, out_keep;
  logic                  mvalid_q, mvalid_d, mlast_q, mlast_d;
  logic                  err_q, err_d;
  logic                  out_free, out_load, out_last;

  function automatic logic [31:0] popcnt(input logic [KEEP_WIDTH-1:0] k);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < int'(KEEP_WIDTH); i++) c = c + 32'(k[i]);
    return c;
  endfunction

  assign out_free = !mvalid_q || m_axis_tready;

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    err_d         = 1'b0;
    tbl_valid_d   = tbl_valid_q;
    tbl_we        = 1'b0;
    wd_addr_d     = wd_addr_q;
    wd_len_d      = wd_len_q;
    wd_tag_d      = wd_tag_q;
    wd_valid_d    = wd_valid_q;
    rd_addr_d     = rd_addr_q;
    rd_len_d      = rd_len_q;
    rd_tag_d      = rd_tag_q;
    rd_valid_d    = rd_valid_q;
    slot_d        = slot_q;
    hdr_last_d    = hdr_last_q;
    res_data_d    = res_data_q;
    res_keep_d    = res_keep_q;
    cnt_d         = cnt_q;
    mvalid_d      = mvalid_q && !m_axis_tready;
    mdata_d       = mdata_q;
    mkeep_d       = mkeep_q;
    mlast_d       = mlast_q;
    out_load      = 1'b0;
    out_last      = 1'b0;
    // Residue fills the low bytes; the new beat is shifted up behind it.
    out_data      = res_data_q | (s_axis_tdata << ((DATA_BYTES - SHIFT) * 8));
    out_keep      = res_keep_q | (s_axis_tkeep << (DATA_BYTES - SHIFT));

    case (state_q)
      StIdle: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          err_d = 1'b1;
          if (id_ok) begin
            case (hdr_func)
              2'b00: begin
                if (hdr_size_valid && size_ok) begin
                  err_d                 = 1'b0;
                  tbl_we                = 1'b1;
                  tbl_valid_d[hdr_slot] = 1'b1;
                  wd_addr_d             = ADDR_WIDTH'(hdr_addr);
                  wd_len_d              = hdr_size[LEN_WIDTH-1:0];
                  wd_tag_d              = TAG_WIDTH'(hdr_slot);
                  wd_valid_d            = 1'b1;
                  slot_d                = hdr_slot;
                  hdr_last_d            = s_axis_tlast;
                  res_data_d            = s_axis_tdata >> (SHIFT * 8);
                  res_keep_d            = s_axis_tkeep >> SHIFT;
                  cnt_d                 = '0;
                  state_d               = StWrDesc;
                end
              end
              2'b01: begin
                if (tbl_valid_q[hdr_slot]) begin
                  err_d      = 1'b0;
                  rd_addr_d  = tbl_addr_q[hdr_slot];
                  rd_len_d   = tbl_size_q[hdr_slot];
                  rd_tag_d   = TAG_WIDTH'(hdr_slot);
                  rd_valid_d = 1'b1;
                  slot_d     = hdr_slot;
                  state_d    = StRdDesc;
                end
              end
              2'b10: begin
                err_d                 = 1'b0;
                tbl_valid_d[hdr_slot] = 1'b0;
                state_d               = s_axis_tlast ? StIdle : StDrop;
              end
              default: ;
            endcase
          end
          if (err_d) state_d = s_axis_tlast ? StIdle : StDrop;
        end
      end
      StWrDesc: begin
        if (m_axis_write_desc_ready) begin
          wd_valid_d = 1'b0;
          state_d    = hdr_last_q ? StFlush : StStream;
        end
      end
      StStream: begin
        s_axis_tready = out_free;
        if (s_axis_tvalid && out_free) begin
          out_load   = 1'b1;
          res_data_d = s_axis_tdata >> (SHIFT * 8);
          res_keep_d = s_axis_tkeep >> SHIFT;
          if (s_axis_tlast) begin
            if ((s_axis_tkeep >> SHIFT) != '0) begin
              state_d = StFlush;
            end else begin
              out_last = 1'b1;
              state_d  = StIdle;
            end
          end
        end
      end
      StFlush: begin
        if (out_free) begin
          out_load = 1'b1;
          out_data = res_data_q;
          out_keep = res_keep_q;
          out_last = 1'b1;
          state_d  = StIdle;
        end
      end
      StRdDesc: begin
        if (m_axis_read_desc_ready) begin
          rd_valid_d = 1'b0;
          state_d    = StRdWait;
        end
      end
      StRdWait: begin
        if (s_axis_read_desc_status_valid &&
            s_axis_read_desc_status_tag == TAG_WIDTH'(slot_q)) begin
          state_d = StIdle;
        end
      end
      StDrop: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (out_load) begin
      mvalid_d = 1'b1;
      mdata_d  = out_data;
      mkeep_d  = out_keep;
      mlast_d  = out_last;
      cnt_d    = cnt_q + popcnt(out_keep);
      // Short or long frame: descriptor is already out, so only flag and retire the slot.
      if (out_last && (cnt_d != 32'(tbl_size_q[slot_q]))) begin
        err_d               = 1'b1;
        tbl_valid_d[slot_q] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tbl_valid_q <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        tbl_addr_q[i] <= '0;
        tbl_size_q[i] <= '0;
      end
      wd_addr_q  <= '0;
      wd_len_q   <= '0;
      wd_tag_q   <= '0;
      wd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_tag_q   <= '0;
      rd_valid_q <= 1'b0;
      slot_q     <= '0;
      hdr_last_q <= 1'b0;
      res_data_q <= '0;
      res_keep_q <= '0;
      cnt_q      <= '0;
      mdata_q    <= '0;
      mkeep_q    <= '0;
      mvalid_q   <= 1'b0;
      mlast_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_valid_q <= tbl_valid_d;
      if (tbl_we) begin
        tbl_addr_q[hdr_slot] <= ADDR_WIDTH'(hdr_addr);
        tbl_size_q[hdr_slot] <= hdr_size[LEN_WIDTH-1:0];
      end
      wd_addr_q  <= wd_addr_d;
      wd_len_q   <= wd_len_d;
      wd_tag_q   <= wd_tag_d;
      wd_valid_q <= wd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_tag_q   <= rd_tag_d;
      rd_valid_q <= rd_valid_d;
      slot_q     <= slot_d;
      hdr_last_q <= hdr_last_d;
      res_data_q <= res_data_d;
      res_keep_q <= res_keep_d;
      cnt_q      <= cnt_d;
      mdata_q    <= mdata_d;
      mkeep_q    <= mkeep_d;
      mvalid_q   <= mvalid_d;
      mlast_q    <= mlast_d;
      err_q      <= err_d;
    end
  end

  assign m_axis_tdata            = mdata_q;
  assign m_axis_tkeep            = mkeep_q;
  assign m_axis_tvalid           = mvalid_q;
  assign m_axis_tlast            = mlast_q;
  assign m_axis_write_desc_addr  = wd_addr_q;
  assign m_axis_write_desc_len   = wd_len_q;
  assign m_axis_write_desc_tag   = wd_tag_q;
  assign m_axis_write_desc_valid = wd_valid_q;
  assign m_axis_read_desc_addr   = rd_addr_q;
  assign m_axis_read_desc_len    = rd_len_q;
  assign m_axis_read_desc_tag    = rd_tag_q;
  assign m_axis_read_desc_valid  = rd_valid_q;
  assign stat_slot_valid         = tbl_valid_q;
  assign stat_err                = err_q;
  assign busy                    = (state_q != StIdle);

endmodule

// File: tb/tb_recon_slot_manager.sv
// Randomized scoreboard bench for recon_slot_manager: a byte-level frame model predicts
// descriptors, realigned payload beats, error pulses and slot-table contents.
module tb_recon_slot_manager;
  localparam int DW = 512, DB = 64, AW = 34, LW = 20, TW = 8, HO = 46, NS = 8, SH = 56;

  logic clk = 1'b0, rst;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [DB-1:0] s_axis_tkeep, m_axis_tkeep;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [AW-1:0] wd_addr, rd_addr;
  logic [LW-1:0] wd_len, rd_len;
  logic [TW-1:0] wd_tag, rd_tag, st_tag;
  logic wd_valid, wd_ready, rd_valid, rd_ready, st_valid;
  logic [NS-1:0] stat_slot_valid;
  logic stat_err, busy;

  always #5 clk = ~clk;

  recon_slot_manager dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_write_desc_addr(wd_addr), .m_axis_write_desc_len(wd_len),
    .m_axis_write_desc_tag(wd_tag), .m_axis_write_desc_valid(wd_valid),
    .m_axis_write_desc_ready(wd_ready),
    .m_axis_read_desc_addr(rd_addr), .m_axis_read_desc_len(rd_len),
    .m_axis_read_desc_tag(rd_tag), .m_axis_read_desc_valid(rd_valid),
    .m_axis_read_desc_ready(rd_ready),
    .s_axis_read_desc_status_tag(st_tag), .s_axis_read_desc_status_valid(st_valid),
    .stat_slot_valid(stat_slot_valid), .stat_err(stat_err), .busy(busy)
  );

  typedef struct {logic [DW-1:0] d; logic [DB-1:0] k; logic l;} beat_t;
  typedef struct {logic [AW-1:0] a; logic [LW-1:0] l; logic [TW-1:0] t;} desc_t;

  beat_t frame_q[$], exp_out[$];
  desc_t exp_wd[$], exp_rd[$];
  logic [7:0] pay[$];
  bit m_valid[NS];
  logic [AW-1:0] m_addr[NS];
  int m_size[NS];
  int n_checks = 0, n_fail = 0, err_exp = 0, err_seen = 0, rd_hs = 0, rmode = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_wide(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask

  function automatic logic [NS-1:0] model_bits();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [79:0] mk_hdr(input logic [1:0] f, input bit sv, input logic [33:0] a,
                                         input logic [7:0] id, input logic [31:0] sz);
    logic [79:0] h;
    h = '0;
    h[1:0] = f;
    h[2] = sv;
    h[36:3] = a;
    h[44:37] = id;
    h[76:45] = sz;
    return h;
  endfunction

  // Ready/backpressure generator, updated just after each rising edge.
  initial begin
    m_axis_tready = 1'b0;
    wd_ready = 1'b0;
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: m_axis_tready = 1'($urandom_range(0, 1));
        1: m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'b1;
      endcase
      wd_ready = 1'($urandom_range(0, 1));
      rd_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output stream monitor: scoreboard pop plus hold-while-stalled checks.
  initial begin
    beat_t e;
    logic [DW-1:0] mask, pd;
    logic [DB-1:0] pk;
    logic pl;
    bit stall;
    stall = 0;
    pd = '0;
    pk = '0;
    pl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0;
      end else begin
        if (stall) begin
          check("out_hold_valid", 64'(m_axis_tvalid), 64'd1);
          check_wide("out_hold_data", m_axis_tdata, pd);
          check("out_hold_keep", 64'(m_axis_tkeep), 64'(pk));
          check("out_hold_last", 64'(m_axis_tlast), 64'(pl));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_out.size() == 0) begin
            fail_now("out_unexpected_beat");
          end else begin
            e = exp_out.pop_front();
            for (int i = 0; i < DB; i++) mask[i*8 +: 8] = {8{e.k[i]}};
            check("out_keep", 64'(m_axis_tkeep), 64'(e.k));
            check("out_last", 64'(m_axis_tlast), 64'(e.l));
            check_wide("out_data", m_axis_tdata & mask, e.d & mask);
          end
        end
        stall = m_axis_tvalid && !m_axis_tready;
        pd = m_axis_tdata;
        pk = m_axis_tkeep;
        pl = m_axis_tlast;
      end
    end
  end

  // Descriptor and error monitors.
  initial begin
    desc_t d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stat_err) err_seen++;
        if (wd_valid && wd_ready) begin
          if (exp_wd.size() == 0) fail_now("write_desc_unexpected");
          else begin
            d = exp_wd.pop_front();
            check("wdesc_addr", 64'(wd_addr), 64'(d.a));
            check("wdesc_len", 64'(wd_len), 64'(d.l));
            check("wdesc_tag", 64'(wd_tag), 64'(d.t));
          end
        end
        if (rd_valid && rd_ready) begin
          rd_hs++;
          if (exp_rd.size() == 0) fail_now("read_desc_unexpected");
          else begin
            d = exp_rd.pop_front();
            check("rdesc_addr", 64'(rd_addr), 64'(d.a));
            check("rdesc_len", 64'(rd_len), 64'(d.l));
            check("rdesc_tag", 64'(rd_tag), 64'(d.t));
          end
        end
      end
    end
  end

  task automatic build_frame(input logic [79:0] hdr, input int p);
    beat_t b;
    int idx;
    idx = 0;
    frame_q.delete();
    pay.delete();
    for (int i = 0; i < p; i++) pay.push_back(8'($urandom()));
    b.d = rand_wide();
    b.d[HO*8 +: 80] = hdr;
    b.k = '0;
    for (int i = 0; i < DB; i++) begin
      if (i < SH + p) begin
        b.k[i] = 1'b1;
        if (i >= SH) begin
          b.d[i*8 +: 8] = pay[idx];
          idx++;
        end
      end
    end
    b.l = (p <= DB - SH);
    frame_q.push_back(b);
    while (idx < p) begin
      b.d = rand_wide();
      b.k = '0;
      for (int i = 0; i < DB; i++) begin
        if (idx < p) begin
          b.d[i*8 +: 8] = pay[idx];
          b.k[i] = 1'b1;
          idx++;
        end
      end
      b.l = (idx >= p);
      frame_q.push_back(b);
    end
  endtask

  // Payload is one contiguous byte string; the realigned output is just its 64-byte chunks.
  task automatic push_exp_out();
    beat_t e;
    for (int off = 0; off < pay.size(); off += DB) begin
      e.d = '0;
      e.k = '0;
      for (int i = 0; i < DB; i++) begin
        if (off + i < pay.size()) begin
          e.d[i*8 +: 8] = pay[off+i];
          e.k[i] = 1'b1;
        end
      end
      e.l = (off + DB >= pay.size());
      exp_out.push_back(e);
    end
  endtask

  task automatic send_beats(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_axis_tdata = frame_q[i].d;
      s_axis_tkeep = frame_q[i].k;
      s_axis_tlast = frame_q[i].l;
      s_axis_tvalid = 1'b1;
      g = 0;
      #1;
      while (!s_axis_tready && g < 400) begin
        @(negedge clk);
        #1;
        g++;
      end
      if (g >= 400) begin
        fail_now("input_beat_timeout");
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int g;
    g = 0;
    while ((busy || m_axis_tvalid || exp_out.size() != 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) fail_now({nm, "_idle_timeout"});
    repeat (3) @(negedge clk);
  endtask

  task automatic finish_load(input logic [2:0] slot, input int hs0);
    int g;
    g = 0;
    while (rd_hs == hs0 && g < 500) begin
      @(negedge clk);
      #2;
      g++;
    end
    if (g >= 500) fail_now("read_desc_timeout");
    @(negedge clk);
    check("load_busy_rdwait", 64'(busy), 64'd1);
    st_tag = TW'(slot ^ 3'd7);
    st_valid = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("load_wrong_tag_ignored", 64'(busy), 64'd1);
    st_tag = TW'(slot);
    st_valid = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    check("load_done_idle", 64'(busy), 64'd0);
  endtask

  task automatic do_frame(input string nm, input logic [1:0] f, input bit sv,
                          input logic [33:0] a, input logic [7:0] id, input logic [31:0] sz,
                          input int p);
    logic [2:0] slot;
    bit err, is_load;
    desc_t d;
    int hs0;
    slot = id[2:0];
    err = 0;
    is_load = 0;
    build_frame(mk_hdr(f, sv, a, id, sz), p);
    if (id >= NS) err = 1;
    else begin
      case (f)
        2'd0: begin
          if (sv && sz != 0 && sz < (32'd1 << LW)) begin
            d.a = AW'(a);
            d.l = sz[LW-1:0];
            d.t = TW'(slot);
            exp_wd.push_back(d);
            push_exp_out();
            m_valid[slot] = 1;
            m_addr[slot] = AW'(a);
            m_size[slot] = int'(sz);
            if (p != int'(sz)) begin
              err = 1;
              m_valid[slot] = 0;
            end
          end else err = 1;
        end
        2'd1: begin
          if (m_valid[slot]) begin
            is_load = 1;
            d.a = m_addr[slot];
            d.l = LW'(m_size[slot]);
            d.t = TW'(slot);
            exp_rd.push_back(d);
          end else err = 1;
        end
        2'd2: m_valid[slot] = 0;
        default: err = 1;
      endcase
    end
    if (err) err_exp++;
    hs0 = rd_hs;
    send_beats(frame_q.size());
    if (is_load) finish_load(slot, hs0);
    wait_idle(nm);
    check({nm, "_slot_valid"}, 64'(stat_slot_valid), 64'(model_bits()));
    check({nm, "_err_count"}, 64'(err_seen), 64'(err_exp));
  endtask

  initial begin
    #3_000_000;
    fail_now("global_watchdog");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [33:0] a;
    logic [31:0] sz;
    logic [7:0] id;
    int p, op;
    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    st_tag = '0;
    st_valid = 1'b0;
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0;
      m_addr[i] = '0;
      m_size[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_wdesc_valid", 64'(wd_valid), 64'd0);
    check("rst_rdesc_valid", 64'(rd_valid), 64'd0);
    check("rst_slot_valid", 64'(stat_slot_valid), 64'd0);
    check("rst_stat_err", 64'(stat_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wdesc_addr", 64'(wd_addr), 64'd0);
    check_wide("rst_m_tdata", m_axis_tdata, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_frame("store2", 2'd0, 1, 34'h1000, 8'd2, 32'd200, 200);
    do_frame("load2", 2'd1, 0, 34'h0, 8'd2, 32'd0, 4);
    do_frame("load3_invalid", 2'd1, 0, 34'h0, 8'd3, 32'd0, 70);
    rmode = 1;
    do_frame("store5_toggle", 2'd0, 1, 34'h2_3456_7890, 8'd5, 32'd300, 300);
    rmode = 0;
    do_frame("store2_short", 2'd0, 1, 34'h1000, 8'd2, 32'd300, 200);
    do_frame("store2_again", 2'd0, 1, 34'h1400, 8'd2, 32'd100, 100);
    do_frame("inval2", 2'd2, 0, 34'h0, 8'd2, 32'd0, 3);
    do_frame("inval2_twice", 2'd2, 0, 34'h0, 8'd2, 32'd0, 90);
    do_frame("store_1beat", 2'd0, 1, 34'h40, 8'd7, 32'd5, 5);
    do_frame("store_8byte", 2'd0, 1, 34'h80, 8'd6, 32'd8, 8);
    do_frame("store_size0", 2'd0, 1, 34'h80, 8'd1, 32'd0, 20);
    do_frame("store_overflow", 2'd0, 1, 34'h80, 8'd1, 32'h0010_0000, 20);
    do_frame("store_nosv", 2'd0, 0, 34'h80, 8'd1, 32'd20, 20);
    do_frame("func3", 2'd3, 1, 34'h80, 8'd1, 32'd20, 80);
    do_frame("bad_id", 2'd0, 1, 34'h80, 8'd8, 32'd20, 20);
    do_frame("store_exact64", 2'd0, 1, 34'h100, 8'd0, 32'd64, 64);

    // Reset in the middle of a streamed store.
    rmode = 0;
    build_frame(mk_hdr(2'd0, 1, 34'h3000, 8'd1, 32'd200), 200);
    begin
      desc_t d;
      d.a = AW'(34'h3000);
      d.l = LW'(200);
      d.t = TW'(1);
      exp_wd.push_back(d);
    end
    push_exp_out();
    send_beats(2);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_wdesc_valid", 64'(wd_valid), 64'd0);
    check("midrst_rdesc_valid", 64'(rd_valid), 64'd0);
    check("midrst_slot_valid", 64'(stat_slot_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    exp_out.delete();
    exp_wd.delete();
    exp_rd.delete();
    for (int i = 0; i < NS; i++) m_valid[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    wait_idle("midrst");
    check("midrst_after_slot_valid", 64'(stat_slot_valid), 64'd0);
    do_frame("post_rst_store", 2'd0, 1, 34'h5000, 8'd4, 32'd130, 130);

    for (int it = 0; it < 25; it++) begin
      rmode = $urandom_range(0, 2);
      op = $urandom_range(0, 9);
      id = 8'($urandom_range(0, 7));
      a = {2'($urandom()), 32'($urandom())};
      if (op < 4) begin
        sz = 32'($urandom_range(1, 400));
        p = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 400) : int'(sz);
        do_frame("rnd_store", 2'd0, 1, a, id, sz, p);
      end else if (op < 7) begin
        p = m_valid[id[2:0]] ? $urandom_range(1, 8) : $urandom_range(1, 150);
        do_frame("rnd_load", 2'd1, 0, a, id, 32'd0, p);
      end else if (op < 8) begin
        do_frame("rnd_inval", 2'd2, 0, a, id, 32'd0, $urandom_range(1, 100));
      end else if (op < 9) begin
        do_frame("rnd_func3", 2'd3, 1, a, id, 32'd10, $urandom_range(1, 100));
      end else begin
        do_frame("rnd_badid", 2'($urandom_range(0, 2)), 1, a, 8'($urandom_range(8, 255)),
                 32'd10, $urandom_range(1, 100));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
